// File: rtl/counter_seq_if.sv
// ---------------------------------------------------------------------------
// counter_seq_if
// Purpose : bundles the control inputs and status outputs of counter_seq so
//           that the controller and the counter connect through one port.
// Signals :
//   start    launch request (sampled only while the counter is idle)
//   stop     abort request (sampled while running or done)
//   dir      0 = count up, 1 = count down
//   mode     0 = one-shot, 1 = auto-reload
//   limit    [BITS] terminal value (up) / start value (down)
//   prescale [PW]   one step every prescale+1 cycles
//   count    [BITS] registered counter value
//   busy     high while the counter is running
//   done     one-cycle pulse when a one-shot run finishes
//   wrap     one-cycle pulse following an auto-reload
// Modports: master drives the controls and reads status; slave is the counter.
// ---------------------------------------------------------------------------
interface counter_seq_if #(
  parameter int BITS = 4,
  parameter int PW   = 4
);
  logic            start;
  logic            stop;
  logic            dir;
  logic            mode;
  logic [BITS-1:0] limit;
  logic [PW-1:0]   prescale;
  logic [BITS-1:0] count;
  logic            busy;
  logic            done;
  logic            wrap;

  modport master (
    output start, stop, dir, mode, limit, prescale,
    input  count, busy, done, wrap
  );

  modport slave (
    input  start, stop, dir, mode, limit, prescale,
    output count, busy, done, wrap
  );
endinterface

// File: rtl/counter_seq.sv
// ---------------------------------------------------------------------------
// counter_seq
// Purpose : prescaled up/down counter sequenced by a three-state FSM
//           (IDLE -> RUN -> DONE -> IDLE). A start in IDLE latches direction,
//           mode, limit and prescale; the counter then steps once every
//           prescale+1 cycles. One-shot runs end in a single DONE cycle,
//           auto-reload runs restart from the start value and pulse wrap.
// Ports   :
//   clk     single clock, all state changes on the rising edge
//   rst     synchronous active-high reset, highest priority
//   cnt_if  counter_seq_if.slave: start/stop/dir/mode/limit/prescale in,
//           count/busy/done/wrap out
// All outputs are registered or decoded from the state register only.
// ---------------------------------------------------------------------------
module counter_seq #(
  parameter int BITS = 4,
  parameter int PW   = 4
) (
  input  logic          clk,
  input  logic          rst,
  counter_seq_if.slave  cnt_if
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // State and datapath registers
  state_t          r_state;
  logic [BITS-1:0] r_count;
  logic [PW-1:0]   r_pc;
  logic            r_wrap;

  // Values captured at start; the live inputs are ignored until next start
  logic            r_dir;
  logic            r_mode;
  logic [BITS-1:0] r_limit;
  logic [PW-1:0]   r_prescale;

  // Next-state values from the combinational process
  state_t          w_state_next;
  logic [BITS-1:0] w_count_next;
  logic [PW-1:0]   w_pc_next;
  logic            w_wrap_next;
  logic            w_dir_next;
  logic            w_mode_next;
  logic [BITS-1:0] w_limit_next;
  logic [PW-1:0]   w_prescale_next;

  // Step/terminal decode on the latched configuration
  logic            w_step;
  logic [BITS-1:0] w_terminal;
  logic [BITS-1:0] w_start_value;
  logic            w_at_terminal;

  // The prescale counter hits the latched divider on the last cycle of
  // each displayed value, so a step lands every prescale+1 cycles.
  assign w_step        = (r_pc == r_prescale);
  assign w_terminal    = r_dir ? '0 : r_limit;
  assign w_start_value = r_dir ? r_limit : '0;
  assign w_at_terminal = (r_count == w_terminal);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_pc       <= '0;
      r_wrap     <= 1'b0;
      r_dir      <= 1'b0;
      r_mode     <= 1'b0;
      r_limit    <= '0;
      r_prescale <= '0;
    end else begin
      r_state    <= w_state_next;
      r_count    <= w_count_next;
      r_pc       <= w_pc_next;
      r_wrap     <= w_wrap_next;
      r_dir      <= w_dir_next;
      r_mode     <= w_mode_next;
      r_limit    <= w_limit_next;
      r_prescale <= w_prescale_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath logic
  // -------------------------------------------------------------------------
  always_comb begin
    // Hold everything by default; wrap is a pulse so it defaults low.
    w_state_next    = r_state;
    w_count_next    = r_count;
    w_pc_next       = r_pc;
    w_wrap_next     = 1'b0;
    w_dir_next      = r_dir;
    w_mode_next     = r_mode;
    w_limit_next    = r_limit;
    w_prescale_next = r_prescale;

    case (r_state)
      S_IDLE: begin
        w_pc_next = '0;
        // A simultaneous stop cancels the launch.
        if (cnt_if.start && !cnt_if.stop) begin
          w_dir_next      = cnt_if.dir;
          w_mode_next     = cnt_if.mode;
          w_limit_next    = cnt_if.limit;
          w_prescale_next = cnt_if.prescale;
          w_count_next    = cnt_if.dir ? cnt_if.limit : '0;
          w_state_next    = S_RUN;
        end
      end

      S_RUN: begin
        if (cnt_if.stop) begin
          // Abort freezes the count; the pending step is discarded.
          w_pc_next    = '0;
          w_state_next = S_IDLE;
        end else if (w_step) begin
          w_pc_next = '0;
          if (w_at_terminal) begin
            if (r_mode) begin
              w_count_next = w_start_value;
              w_wrap_next  = 1'b1;
            end else begin
              w_state_next = S_DONE;
            end
          end else if (r_dir) begin
            w_count_next = r_count - 1'b1;
          end else begin
            w_count_next = r_count + 1'b1;
          end
        end else begin
          w_pc_next = r_pc + 1'b1;
        end
      end

      S_DONE: begin
        // Single-cycle state whether or not stop is asserted.
        w_pc_next    = '0;
        w_state_next = S_IDLE;
      end

      default: begin
        w_pc_next    = '0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign cnt_if.count = r_count;
  assign cnt_if.busy  = (r_state == S_RUN);
  assign cnt_if.done  = (r_state == S_DONE);
  assign cnt_if.wrap  = r_wrap;

endmodule

// File: tb/tb_counter_seq.sv
// ---------------------------------------------------------------------------
// tb_counter_seq
// Drives counter_seq with directed scenarios followed by random stimulus.
// The reference model tracks only the phase (idle/run/done) and the number
// of cycles spent in RUN; the expected count is derived arithmetically from
// that elapsed time and the configuration captured at start.
// ---------------------------------------------------------------------------
module tb_counter_seq;
  localparam int BITS = 4;
  localparam int PW   = 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  counter_seq_if #(.BITS(BITS), .PW(PW)) bus ();

  counter_seq #(.BITS(BITS), .PW(PW)) dut (
    .clk    (clk),
    .rst    (rst),
    .cnt_if (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: 0 = idle, 1 = run, 2 = done
  int m_phase;
  int m_t;      // cycles already spent in RUN
  int m_lim;
  int m_pre;
  int m_dir;
  int m_mode;
  int m_hold;   // count shown while idle

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Count displayed t cycles after RUN entry.
  function automatic int run_count(input int t);
    int s;
    s = t / (m_pre + 1);
    if (m_mode != 0) s = s % (m_lim + 1);
    return (m_dir != 0) ? (m_lim - s) : s;
  endfunction

  function automatic int terminal_value();
    return (m_dir != 0) ? 0 : m_lim;
  endfunction

  // Apply one cycle of inputs, check outputs mid-cycle, advance the model.
  task automatic drive(input int r, input int s, input int p, input int d,
                       input int m, input int lim, input int pre);
    int e_count, e_busy, e_done, e_wrap, s_done;
    rst          = (r != 0);
    bus.start    = (s != 0);
    bus.stop     = (p != 0);
    bus.dir      = (d != 0);
    bus.mode     = (m != 0);
    bus.limit    = BITS'(lim);
    bus.prescale = PW'(pre);

    @(negedge clk);
    e_count = m_hold; e_busy = 0; e_done = 0; e_wrap = 0;
    if (m_phase == 1) begin
      e_count = run_count(m_t);
      e_busy  = 1;
      s_done  = m_t / (m_pre + 1);
      if (m_mode != 0 && m_t > 0 && (m_t % (m_pre + 1)) == 0 &&
          (s_done % (m_lim + 1)) == 0)
        e_wrap = 1;
    end else if (m_phase == 2) begin
      e_count = terminal_value();
      e_done  = 1;
    end
    check("count", int'(bus.count), e_count);
    check("busy",  int'(bus.busy),  e_busy);
    check("done",  int'(bus.done),  e_done);
    check("wrap",  int'(bus.wrap),  e_wrap);

    @(posedge clk);
    if (r != 0) begin
      m_phase = 0; m_hold = 0;
    end else begin
      case (m_phase)
        0: if (s != 0 && p == 0) begin
             m_phase = 1; m_t = 0;
             m_dir = d; m_mode = m; m_lim = lim & 15; m_pre = pre & 15;
             $display("[TB] start dir=%0d mode=%0d limit=%0d prescale=%0d",
                      m_dir, m_mode, m_lim, m_pre);
           end
        1: if (p != 0) begin
             m_hold = run_count(m_t); m_phase = 0;
           end else if (m_mode == 0 && m_t == (m_lim + 1) * (m_pre + 1) - 1) begin
             m_phase = 2;
           end else begin
             m_t++;
           end
        default: begin
          m_hold = terminal_value(); m_phase = 0;
        end
      endcase
    end
    #1;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.dir = 1'b0; bus.mode = 1'b0;
    bus.limit = '0; bus.prescale = '0;
    m_phase = 0; m_t = 0; m_lim = 0; m_pre = 0; m_dir = 0; m_mode = 0; m_hold = 0;
    @(posedge clk);
    #1;

    // Reset state
    drive(1, 0, 0, 0, 0, 0, 0);
    idle_n(2);

    // Up one-shot, limit 3, prescale 0
    drive(0, 1, 0, 0, 0, 3, 0);
    idle_n(7);

    // Down, limit 2, prescale 2
    drive(0, 1, 0, 1, 0, 2, 2);
    idle_n(12);

    // Auto-reload up, limit 1, then stop
    drive(0, 1, 0, 0, 1, 1, 0);
    idle_n(7);
    drive(0, 0, 1, 0, 0, 0, 0);
    idle_n(3);

    // limit 0 one-shot, then limit 15 up with restart right after DONE
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 15, 0);
    idle_n(19);

    // start+stop together in IDLE; start and input changes during RUN
    drive(0, 1, 1, 0, 0, 5, 0);
    idle_n(2);
    drive(0, 1, 0, 0, 0, 4, 1);
    drive(0, 1, 0, 1, 1, 9, 0);
    drive(0, 1, 0, 1, 1, 2, 7);
    idle_n(12);

    // Reset mid-RUN at count 2, then fresh start
    drive(0, 1, 0, 0, 0, 5, 0);
    idle_n(2);
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 2, 0);
    idle_n(6);

    // Random stimulus with live inputs changing every cycle
    for (int i = 0; i < 2500; i++) begin
      int r, s, p, pre;
      r   = ($urandom_range(0, 99) == 0) ? 1 : 0;
      s   = ($urandom_range(0, 3) == 0) ? 1 : 0;
      p   = ($urandom_range(0, 19) == 0) ? 1 : 0;
      pre = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2);
      drive(r, s, p, $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 15), pre);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit so the bench always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish, expected finish before limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/counter_seq.md
COUNTER_SEQ -- requirements
Module: counter_seq

Interface
REQ-001 Parameter BITS, default 4: width of count, limit.
REQ-002 Parameter PW, default 4: width of prescale.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  launch request; sampled in IDLE only.
REQ-006 stop  input  1  abort request; sampled in RUN and DONE.
REQ-007 dir  input  1  count direction: 0 = up, 1 = down; latched at start.
REQ-008 mode  input  1  0 = one-shot, 1 = auto-reload; latched at start.
REQ-009 limit  input  BITS  terminal value for up, start value for down; latched at start.
REQ-010 prescale  input  PW  step divider; one step every prescale+1 cycles; latched at start.
REQ-011 count  output  BITS  registered counter value.
REQ-012 busy  output  1  high while state == RUN.
REQ-013 done  output  1  one-cycle pulse, high while state == DONE.
REQ-014 wrap  output  1  one-cycle registered pulse on auto-reload.

Function
REQ-015 FSM states: IDLE, RUN, DONE; all outputs registered or decoded from state only.
REQ-016 IDLE, start=1, stop=0: latch dir/mode/limit/prescale; count <= 0 (up) or limit (down); pc <= 0; next state RUN.
REQ-017 IDLE, start=1 and stop=1: start ignored; remain IDLE.
REQ-018 IDLE: count holds last value; pc held at 0.
REQ-019 RUN: pc increments each cycle; when pc == latched prescale, pc <= 0 and a step occurs that cycle.
REQ-020 Terminal value: latched limit (up), 0 (down).
REQ-021 Step, count != terminal: count <= count+1 (up) or count-1 (down); no modular wrap possible.
REQ-022 Step, count == terminal, mode=0: count holds; next state DONE.
REQ-023 Step, count == terminal, mode=1: count <= start value (0 up, limit down); wrap = 1 next cycle; stay RUN.
REQ-024 First step occurs prescale+1 cycles after RUN entry; each count value, including terminal, is displayed for prescale+1 cycles.
REQ-025 limit = 0 (up or down): start value equals terminal; first step ends (mode 0) or wraps (mode 1).
REQ-026 DONE: lasts exactly one cycle; next state IDLE; count holds terminal.
REQ-027 stop=1 in RUN: next state IDLE; count holds current value; no step applied that cycle; done and wrap stay 0.
REQ-028 stop=1 in DONE: next state IDLE (unchanged behaviour); done still pulses that cycle.
REQ-029 start in RUN or DONE ignored; input changes after start have no effect until next start.
REQ-030 Restart allowed in the IDLE cycle immediately after DONE.

Reset
REQ-031 rst=1 at a clock edge: state IDLE; count=0, pc=0, busy=0, done=0, wrap=0, latched dir/mode/limit/prescale=0.
REQ-032 rst has priority over start, stop and any step; reset mid-RUN aborts with no done or wrap pulse.

Verification
REQ-033 Up one-shot: limit=3, prescale=0, dir=0, mode=0, start 1 cycle -> count 0,1,2,3 on consecutive RUN cycles; DONE pulse 1 cycle after 3 held 1 cycle; busy 4 cycles; back to IDLE, count=3.
REQ-034 Down with prescale: limit=2, prescale=2, dir=1 -> count 2,1,0, each held 3 cycles; done pulse once; total busy 9 cycles.
REQ-035 Auto-reload: limit=1, prescale=0, dir=0, mode=1 -> count 0,1,0,1...; wrap pulse 1 cycle after each 1->0 reload; done never asserts; stop -> IDLE next cycle, count frozen.
REQ-036 Edge cases: limit=0 one-shot -> busy 1 cycle, done pulse, count=0; limit=15 up -> reaches 15, no overflow to 0.
REQ-037 Priority: start+stop together in IDLE -> stays IDLE; start during RUN -> ignored; input change mid-RUN -> no effect.
REQ-038 Reset mid-RUN (count=2) -> next cycle all outputs 0, state IDLE; fresh start counts normally.
